matrix_inverse_fx: RTL and testbench

MATRIX_INVERSE_FX -- requirements
Module: matrix_inverse_fx

---
 rtl/matrix_inverse_fx.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_matrix_inverse_fx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_inverse_fx.sv
// Fixed-point N x N matrix inverse by Gauss-Jordan elimination with partial pivoting.
// Elements stream in and out row-major; one arithmetic operation per cycle.
module matrix_inverse_fx #(
   parameter int unsigned N    = 5,
   parameter int unsigned W    = 32,
   parameter int unsigned FRAC = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         singular,
   output logic         busy
);
   localparam int unsigned RW  = $clog2(N);
   localparam int unsigned CLW = $clog2(2 * N);
   localparam int unsigned DW  = $clog2(W);
   localparam int unsigned PW  = 2 * W + 1;

   localparam logic [W-1:0]     One      = {{(W-1){1'b0}}, 1'b1} << FRAC;
   localparam logic [W-1:0]     MaxVal   = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]     MinVal   = {1'b1, {(W-1){1'b0}}};
   localparam logic [2*W-1:0]   Dividend = {{(2*W-1){1'b0}}, 1'b1} << (2 * FRAC);
   localparam logic [RW-1:0]    LastRow  = RW'(N - 1);
   localparam logic [CLW-1:0]   LastLdC  = CLW'(N - 1);
   localparam logic [CLW-1:0]   LastCol  = CLW'(2 * N - 1);

   typedef enum logic [2:0] {
      StIdle, StLoad, StSearch, StRecip, StNorm, StElim, StUnload
   } state_e;

   // Floor((a*b) >> FRAC), sign-extended to PW bits.
   function automatic logic [PW-1:0] mul_q(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W-1:0] ea, eb, p;
      ea = {{W{a[W-1]}}, a};
      eb = {{W{b[W-1]}}, b};
      p  = ea * eb;
      return $signed({p[2*W-1], p}) >>> FRAC;
   endfunction

   // Returns {overflow, saturated value}.
   function automatic logic [W:0] sat_w(input logic signed [PW-1:0] v);
      logic signed [PW-1:0] hi, lo;
      hi = {{(PW-W){1'b0}}, MaxVal};
      lo = {{(PW-W){1'b1}}, MinVal};
      if (v > hi)      return {1'b1, MaxVal};
      else if (v < lo) return {1'b1, MinVal};
      else             return {1'b0, v[W-1:0]};
   endfunction

   function automatic logic [W-1:0] abs_w(input logic [W-1:0] v);
      return v[W-1] ? (~v + W'(1)) : v;
   endfunction

   state_e state_q, state_d;
   logic [W-1:0]   mat_q [N][2*N];
   logic [RW-1:0]  k_q, k_d, row_q, row_d, best_row_q, best_row_d;
   logic [CLW-1:0] col_q, col_d;
   logic [W-1:0]   best_abs_q, best_abs_d, best_val_q, best_val_d;
   logic [W-1:0]   fac_q, fac_d, recip_q, recip_d;
   logic [W-1:0]   div_rem_q, div_rem_d, div_num_q, div_num_d, div_quo_q, div_quo_d;
   logic [W-1:0]   div_dvs_q, div_dvs_d;
   logic [DW-1:0]  div_cnt_q, div_cnt_d;
   logic           div_neg_q, div_neg_d, div_ovf_q, div_ovf_d;
   logic           swap_q, swap_d, sing_q, sing_d, ovf_q, ovf_d, out_vld_q, out_vld_d;

   logic           in_hs, out_hs, ld_last, ld_we, swap_en, mat_we;
   logic [RW-1:0]  mat_wr;
   logic [CLW-1:0] mat_wc, kc;
   logic [W-1:0]   mat_wval, cur_val, cur_abs, fin_abs, fin_val, pivot;
   logic [RW-1:0]  fin_row;
   logic           take, search_end, search_zero, search_go;
   logic [W-1:0]   a_kj, a_ij, a_ik, fac, div_sub, div_quo;
   logic [W:0]     div_trial, norm_r, elim_r;
   logic           div_bit, quo_ovf, elim_skip, elim_adv, elim_done;
   int             elim_nxt;

   assign in_hs   = in_valid && in_ready;
   assign out_hs  = out_valid && out_ready;
   assign ld_last = in_hs && (row_q == LastRow) && (col_q == LastLdC);
   assign kc      = CLW'(k_q);

   // Pivot search: lowest row wins ties because only a strictly larger value replaces it.
   assign cur_val     = mat_q[row_q][kc];
   assign cur_abs     = abs_w(cur_val);
   assign take        = (row_q == k_q) || (cur_abs > best_abs_q);
   assign fin_abs     = take ? cur_abs : best_abs_q;
   assign fin_val     = take ? cur_val : best_val_q;
   assign fin_row     = take ? row_q : best_row_q;
   assign search_end  = !swap_q && (row_q == LastRow);
   assign search_zero = search_end && (fin_abs == '0);
   assign search_go   = swap_q || (search_end && (fin_abs != '0) && (fin_row == k_q));
   assign pivot       = swap_q ? best_val_q : fin_val;

   assign div_trial = {div_rem_q, div_num_q[W-1]};
   assign div_bit   = div_trial >= {1'b0, div_dvs_q};
   assign div_sub   = div_trial[W-1:0] - div_dvs_q;
   assign div_quo   = {div_quo_q[W-2:0], div_bit};
   assign quo_ovf   = div_ovf_q || (div_quo[W-1] && !(div_neg_q && (div_quo[W-2:0] == '0)));

   assign a_kj      = mat_q[k_q][col_q];
   assign a_ij      = mat_q[row_q][col_q];
   assign a_ik      = mat_q[row_q][kc];
   assign fac       = (col_q == '0) ? a_ik : fac_q;
   assign norm_r    = sat_w(mul_q(a_kj, recip_q));
   assign elim_r    = sat_w($signed({{(W+1){a_ij[W-1]}}, a_ij}) - mul_q(fac, a_kj));
   assign elim_nxt  = (int'(row_q) + 1 == int'(k_q)) ? int'(row_q) + 2 : int'(row_q) + 1;
   assign elim_skip = (col_q == '0) && (a_ik == '0);
   assign elim_adv  = elim_skip || (col_q == LastCol);
   assign elim_done = elim_adv && (elim_nxt >= int'(N));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (in_hs) state_d = StLoad;
         StLoad:   if (ld_last) state_d = StSearch;
         StSearch: begin
            if (search_zero)    state_d = StUnload;
            else if (search_go) state_d = StRecip;
         end
         StRecip:  if (div_cnt_q == '0) state_d = StNorm;
         StNorm:   if (col_q == LastCol) state_d = StElim;
         StElim:   if (elim_done) state_d = (k_q == LastRow) ? StUnload : StSearch;
         StUnload: if (out_hs && out_last) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == StIdle) || (state_q == StLoad);
      busy      = (state_q != StIdle);
      out_valid = out_vld_q;
      out_last  = out_vld_q && (row_q == LastRow) && (col_q == LastLdC);
      singular  = sing_q || ovf_q;
      out_data  = (out_vld_q && !singular) ? mat_q[row_q][CLW'(N) + col_q] : '0;
   end

   always_comb begin
      k_d = k_q;  row_d = row_q;  col_d = col_q;
      best_row_d = best_row_q;  best_abs_d = best_abs_q;  best_val_d = best_val_q;
      fac_d = fac_q;  recip_d = recip_q;  swap_d = swap_q;
      div_rem_d = div_rem_q;  div_num_d = div_num_q;  div_quo_d = div_quo_q;
      div_dvs_d = div_dvs_q;  div_cnt_d = div_cnt_q;
      div_neg_d = div_neg_q;  div_ovf_d = div_ovf_q;
      sing_d = sing_q;  ovf_d = ovf_q;  out_vld_d = out_vld_q;
      ld_we = 1'b0;  swap_en = 1'b0;  mat_we = 1'b0;
      mat_wr = '0;  mat_wc = '0;  mat_wval = '0;
      unique case (state_q)
         StIdle, StLoad: begin
            if (in_hs) begin
               ld_we = 1'b1;
               if (state_q == StIdle) begin
                  sing_d = 1'b0;
                  ovf_d  = 1'b0;
               end
               if (col_q == LastLdC) begin
                  col_d = '0;
                  row_d = ld_last ? '0 : row_q + RW'(1);
               end else begin
                  col_d = col_q + CLW'(1);
               end
               if (ld_last) k_d = '0;
            end
         end
         StSearch: begin
            if (swap_q) begin
               swap_en = 1'b1;
               swap_d  = 1'b0;
            end else begin
               best_row_d = fin_row;
               best_abs_d = fin_abs;
               best_val_d = fin_val;
               if (search_zero) begin
                  sing_d = 1'b1;
                  row_d  = '0;
                  col_d  = '0;
               end else if (search_end) begin
                  swap_d = (fin_row != k_q);
               end else begin
                  row_d = row_q + RW'(1);
               end
            end
            if (search_go) begin
               div_neg_d = pivot[W-1];
               div_dvs_d = abs_w(pivot);
               div_ovf_d = Dividend[2*W-1:W] >= abs_w(pivot);
               div_rem_d = Dividend[2*W-1:W];
               div_num_d = Dividend[W-1:0];
               div_quo_d = '0;
               div_cnt_d = DW'(W - 1);
            end
         end
         StRecip: begin
            div_rem_d = div_bit ? div_sub : div_trial[W-1:0];
            div_num_d = div_num_q << 1;
            div_quo_d = div_quo;
            div_cnt_d = div_cnt_q - DW'(1);
            if (div_cnt_q == '0) begin
               col_d = '0;
               if (quo_ovf) begin
                  ovf_d   = 1'b1;
                  recip_d = div_neg_q ? MinVal : MaxVal;
               end else begin
                  recip_d = div_neg_q ? (~div_quo + W'(1)) : div_quo;
               end
            end
         end
         StNorm: begin
            mat_we   = 1'b1;
            mat_wr   = k_q;
            mat_wc   = col_q;
            mat_wval = (col_q == kc) ? One : norm_r[W-1:0];
            if (col_q != kc) ovf_d = ovf_q || norm_r[W];
            if (col_q == LastCol) begin
               col_d = '0;
               row_d = (k_q == '0) ? RW'(1) : '0;
            end else begin
               col_d = col_q + CLW'(1);
            end
         end
         StElim: begin
            if (!elim_skip) begin
               mat_we   = 1'b1;
               mat_wr   = row_q;
               mat_wc   = col_q;
               mat_wval = elim_r[W-1:0];
               ovf_d    = ovf_q || elim_r[W];
               if (col_q == '0) fac_d = a_ik;
            end
            if (elim_adv) begin
               col_d = '0;
               if (!elim_done) begin
                  row_d = RW'(elim_nxt);
               end else if (k_q != LastRow) begin
                  k_d   = k_q + RW'(1);
                  row_d = k_q + RW'(1);
               end else begin
                  row_d = '0;
               end
            end else begin
               col_d = col_q + CLW'(1);
            end
         end
         StUnload: begin
            if (!out_vld_q) begin
               out_vld_d = 1'b1;
            end else if (out_ready) begin
               if (out_last) begin
                  out_vld_d = 1'b0;
                  row_d     = '0;
                  col_d     = '0;
               end else if (col_q == LastLdC) begin
                  col_d = '0;
                  row_d = row_q + RW'(1);
               end else begin
                  col_d = col_q + CLW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q <= '0;  row_q <= '0;  col_q <= '0;
         best_row_q <= '0;  best_abs_q <= '0;  best_val_q <= '0;
         fac_q <= '0;  recip_q <= '0;  swap_q <= 1'b0;
         div_rem_q <= '0;  div_num_q <= '0;  div_quo_q <= '0;
         div_dvs_q <= '0;  div_cnt_q <= '0;
         div_neg_q <= 1'b0;  div_ovf_q <= 1'b0;
         sing_q <= 1'b0;  ovf_q <= 1'b0;  out_vld_q <= 1'b0;
      end else begin
         k_q <= k_d;  row_q <= row_d;  col_q <= col_d;
         best_row_q <= best_row_d;  best_abs_q <= best_abs_d;  best_val_q <= best_val_d;
         fac_q <= fac_d;  recip_q <= recip_d;  swap_q <= swap_d;
         div_rem_q <= div_rem_d;  div_num_q <= div_num_d;  div_quo_q <= div_quo_d;
         div_dvs_q <= div_dvs_d;  div_cnt_q <= div_cnt_d;
         div_neg_q <= div_neg_d;  div_ovf_q <= div_ovf_d;
         sing_q <= sing_d;  ovf_q <= ovf_d;  out_vld_q <= out_vld_d;
      end
   end

   // Storage is not reset; a load rewrites both halves, including the identity.
   always_ff @(posedge clk) begin
      if (ld_we) begin
         mat_q[row_q][col_q]            <= in_data;
         mat_q[row_q][CLW'(N) + col_q]  <= (CLW'(row_q) == col_q) ? One : '0;
      end else if (swap_en) begin
         for (int c = 0; c < 2 * N; c++) begin
            mat_q[k_q][CLW'(c)]        <= mat_q[best_row_q][CLW'(c)];
            mat_q[best_row_q][CLW'(c)] <= mat_q[k_q][CLW'(c)];
         end
      end else if (mat_we) begin
         mat_q[mat_wr][mat_wc] <= mat_wval;
      end
   end

endmodule

// File: tb/tb_matrix_inverse_fx.sv
// Directed bench for matrix_inverse_fx: identity, bidiagonal, pivoting, singular,
// backpressure and mid-operation reset, with hand-derived expected inverses.
module tb_matrix_inverse_fx;
   localparam int N       = 5;
   localparam int W       = 32;
   localparam int FRAC    = 16;
   localparam int NN      = N * N;
   localparam int LAT_MAX = N * (N + 2 + W + 2 * N + 2 * N * (N - 1)) + 4;
   localparam logic [W-1:0] ONE = 32'h0001_0000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         singular;
   logic         busy;

   int n_cmp = 0;
   int n_fail = 0;
   logic [W-1:0] mat_in  [NN];
   logic [W-1:0] mat_exp [NN];

   always #5 clk = ~clk;

   matrix_inverse_fx #(.N(N), .W(W), .FRAC(FRAC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .singular  (singular),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_identity(output logic [W-1:0] m [NN]);
      for (int i = 0; i < NN; i++) m[i] = (i / N == i % N) ? ONE : '0;
   endtask

   task automatic load_bidiag();
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            int p = 1;
            mat_in[i*N+j] = (j == i) ? ONE : (j == i + 1) ? 32'h0002_0000 : '0;
            for (int s = 0; s < j - i; s++) p = p * -2;
            mat_exp[i*N+j] = (j < i) ? '0 : 32'(p * 65536);
         end
      end
   endtask

   task automatic send_matrix(input string tag);
      for (int idx = 0; idx < NN; idx++) begin
         int guard = 0;
         in_valid = 1'b1;
         in_data  = mat_in[idx];
         while (!in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
         end
         if (!in_ready) chk({tag, " in_ready timeout"}, in_ready, 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_data  = '0;
      chk({tag, " in_ready low after load"}, in_ready, 0);
   endtask

   task automatic recv(input string tag, input logic exp_sing, input bit throttle);
      int   lat = 0;
      int   beats = 0;
      int   cyc = 0;
      int   extra = 0;
      logic held_v = 1'b0;
      logic held_l = 1'b0;
      logic [W-1:0] held_d = '0;
      while (!out_valid && lat <= LAT_MAX + 10) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency within bound"}, (lat <= LAT_MAX), 1);
      chk({tag, " singular"}, singular, exp_sing);
      while (beats < NN && cyc < 3000) begin
         out_ready = throttle ? (cyc % 3 == 0) : 1'b1;
         if (held_v && out_valid) begin
            chk($sformatf("%s stall data beat %0d", tag, beats), out_data, held_d);
            chk($sformatf("%s stall last beat %0d", tag, beats), out_last, held_l);
         end
         if (out_valid && out_ready) begin
            chk($sformatf("%s data[%0d]", tag, beats), out_data, mat_exp[beats]);
            chk($sformatf("%s last[%0d]", tag, beats), out_last, (beats == NN - 1));
            beats++;
            held_v = 1'b0;
         end else if (out_valid) begin
            held_v = 1'b1;
            held_d = out_data;
            held_l = out_last;
         end else begin
            held_v = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      chk({tag, " handshakes"}, beats, NN);
      chk({tag, " out_valid low after last"}, out_valid, 0);
      chk({tag, " in_ready after last"}, in_ready, 1);
      out_ready = 1'b1;
      repeat (4) begin
         if (out_valid) extra++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk({tag, " no extra beats"}, extra, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " in_ready"}, in_ready, 1);
      chk({tag, " out_valid"}, out_valid, 0);
      chk({tag, " out_last"}, out_last, 0);
      chk({tag, " singular"}, singular, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " out_data"}, out_data, '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      load_identity(mat_in);
      load_identity(mat_exp);
      send_matrix("ident");
      recv("ident", 1'b0, 1'b0);

      load_bidiag();
      send_matrix("bidiag");
      recv("bidiag", 1'b0, 1'b0);

      load_identity(mat_in);
      mat_in[0] = '0;   mat_in[1] = ONE;
      mat_in[5] = ONE;  mat_in[6] = '0;
      for (int i = 0; i < NN; i++) mat_exp[i] = mat_in[i];
      send_matrix("pivot");
      recv("pivot", 1'b0, 1'b0);

      load_identity(mat_in);
      mat_in[2*N+2] = '0;
      for (int i = 0; i < NN; i++) mat_exp[i] = '0;
      send_matrix("singular");
      recv("singular", 1'b1, 1'b0);

      load_bidiag();
      send_matrix("backpressure");
      recv("backpressure", 1'b0, 1'b1);

      load_bidiag();
      send_matrix("midreset");
      guard = 0;
      while (int'(dut.state_q) != 5 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      chk("midreset reached elim", 32'(int'(dut.state_q)), 5);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("midreset out_valid after release", out_valid, 0);
      load_identity(mat_in);
      load_identity(mat_exp);
      send_matrix("post-reset ident");
      recv("post-reset ident", 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
